// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the five-stage RV32IM pipeline. Every
// cycle it decides whether PC, IF_ID, ID_EX and EX_MEM load, hold or take a
// bubble. It resolves four conditions: memory busy-wait, multi-cycle MUL/DIV
// in EX, control redirects resolved in EX, and load-use hazards between ID
// and EX.
//
// Parameters:
//   MD_LATENCY   EX occupancy of a MUL/DIV instruction in cycles (>=1).
//                A value of 1 disables the MUL/DIV wait entirely.
//
// Ports:
//   CLK, RESET          clock; asynchronous active-low reset
//   BUSYWAIT            instruction or data memory not ready
//   ID_RS1/2, ID_USES_* source registers of the ID instruction, with use flags
//   EX_RD, EX_MEMREAD   destination and load flag of the EX instruction
//   EX_MULDIV           EX instruction is an M-extension op
//   EX_REDIRECT         taken branch / jump resolved in EX
//   *_WRITE, *_FLUSH    pipeline register load enables and bubble inserts
//   MD_START            one-cycle start pulse to the MUL/DIV unit
//   MD_BUSY             controller is waiting on the MUL/DIV unit
//
// Optional feature (macro PIPE_PERF_CNT_EN):
//   STALL_CYCLES        cycles out of reset with PC_WRITE=0 (wraps)
//   FLUSH_EVENTS        cycles in which a redirect flush was issued (wraps)

module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUSYWAIT,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_USES_RS1,
    input  logic       ID_USES_RS2,
    input  logic [4:0] EX_RD,
    input  logic       EX_MEMREAD,
    input  logic       EX_MULDIV,
    input  logic       EX_REDIRECT,
    output logic       PC_WRITE,
    output logic       IF_ID_WRITE,
    output logic       IF_ID_FLUSH,
    output logic       ID_EX_WRITE,
    output logic       ID_EX_FLUSH,
    output logic       EX_MEM_WRITE,
    output logic       MD_START,
    output logic       MD_BUSY
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] STALL_CYCLES,
    output logic [31:0] FLUSH_EVENTS
`endif
);

    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam bit MD_EN = (MD_LATENCY >= 2);
    // The start cycle and the release cycle are both part of the occupancy,
    // so the counter only has to cover the stall cycles in between.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MD_LATENCY >= 2) ? MD_LATENCY - 2 : 0);

    typedef enum logic {S_RUN, S_MD_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
    logic             lu_hazard;
    logic             md_issue;
    logic             cnt_live;

    assign lu_hazard = EX_MEMREAD && (EX_RD != 5'd0) &&
                       ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                        (ID_USES_RS2 && (ID_RS2 == EX_RD)));
    assign md_issue  = (state == S_RUN) && EX_MULDIV && MD_EN;
    assign cnt_live  = (state == S_MD_WAIT) && (md_cnt != '0);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= S_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Next-state logic. The wait counter keeps running under BUSYWAIT so a
    // long memory stall absorbs the MUL/DIV latency instead of adding to it.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        if (BUSYWAIT) begin
            if (cnt_live) md_cnt_nxt = md_cnt - 1'b1;
        end else if (md_issue) begin
            state_nxt  = S_MD_WAIT;
            md_cnt_nxt = CNT_LOAD;
        end else if (cnt_live) begin
            md_cnt_nxt = md_cnt - 1'b1;
        end else if (state == S_MD_WAIT) begin
            state_nxt = S_RUN;
        end
    end

    // Output logic. Everything is forced low while RESET is asserted so the
    // pipeline is frozen regardless of what the inputs are doing.
    always_comb begin
        PC_WRITE     = 1'b0;
        IF_ID_WRITE  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_WRITE  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_WRITE = 1'b0;
        MD_START     = 1'b0;
        if (!RESET || BUSYWAIT) begin
            // frozen
        end else if (md_issue) begin
            MD_START = 1'b1;
        end else if (cnt_live) begin
            // still waiting on MUL/DIV
        end else if (state == S_MD_WAIT) begin
            // release: hazards are not checked because ID has been held and
            // EX still holds the MUL/DIV, which is not a load or a redirect
            PC_WRITE     = 1'b1;
            IF_ID_WRITE  = 1'b1;
            ID_EX_WRITE  = 1'b1;
            EX_MEM_WRITE = 1'b1;
        end else if (EX_REDIRECT) begin
            // redirect squashes the ID instruction, so any load-use is moot
            PC_WRITE     = 1'b1;
            IF_ID_WRITE  = 1'b1;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_WRITE  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_WRITE = 1'b1;
        end else if (lu_hazard) begin
            // hold PC/IF_ID one cycle and push a bubble into EX
            ID_EX_WRITE  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_WRITE = 1'b1;
        end else begin
            PC_WRITE     = 1'b1;
            IF_ID_WRITE  = 1'b1;
            ID_EX_WRITE  = 1'b1;
            EX_MEM_WRITE = 1'b1;
        end
    end

    assign MD_BUSY = RESET && (state == S_MD_WAIT);

`ifdef PIPE_PERF_CNT_EN
    // IF_ID_FLUSH is only ever raised by a redirect, so it marks the event.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STALL_CYCLES <= '0;
            FLUSH_EVENTS <= '0;
        end else begin
            if (!PC_WRITE)   STALL_CYCLES <= STALL_CYCLES + 32'd1;
            if (IF_ID_FLUSH) FLUSH_EVENTS <= FLUSH_EVENTS + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Main instance uses MD_LATENCY=4;
// a second instance with MD_LATENCY=1 shares the inputs to show MUL/DIV is
// ignored there. Output vector: {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F,
// EXMEM_W, MD_START, MD_BUSY}.

module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET, BUSYWAIT;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_MULDIV, EX_REDIRECT;

    logic pcw0, ifw0, iff0, idw0, idf0, exw0, mds0, mdb0;
    logic pcw1, ifw1, iff1, idw1, idf1, exw1, mds1, mdb1;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall0, flush0, stall1, flush1;
`endif

    logic [7:0] out0, out1;
    assign out0 = {pcw0, ifw0, iff0, idw0, idf0, exw0, mds0, mdb0};
    assign out1 = {pcw1, ifw1, iff1, idw1, idf1, exw1, mds1, mdb1};

    localparam logic [7:0] OFF   = 8'b0000_0000;
    localparam logic [7:0] RUNW  = 8'b1101_0100;
    localparam logic [7:0] REDIR = 8'b1111_1100;
    localparam logic [7:0] LU    = 8'b0001_1100;
    localparam logic [7:0] START = 8'b0000_0010;
    localparam logic [7:0] WAIT  = 8'b0000_0001;
    localparam logic [7:0] REL   = 8'b1101_0101;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD), .EX_MULDIV(EX_MULDIV),
        .EX_REDIRECT(EX_REDIRECT),
        .PC_WRITE(pcw0), .IF_ID_WRITE(ifw0), .IF_ID_FLUSH(iff0),
        .ID_EX_WRITE(idw0), .ID_EX_FLUSH(idf0), .EX_MEM_WRITE(exw0),
        .MD_START(mds0), .MD_BUSY(mdb0)
`ifdef PIPE_PERF_CNT_EN
        , .STALL_CYCLES(stall0), .FLUSH_EVENTS(flush0)
`endif
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD), .EX_MULDIV(EX_MULDIV),
        .EX_REDIRECT(EX_REDIRECT),
        .PC_WRITE(pcw1), .IF_ID_WRITE(ifw1), .IF_ID_FLUSH(iff1),
        .ID_EX_WRITE(idw1), .ID_EX_FLUSH(idf1), .EX_MEM_WRITE(exw1),
        .MD_START(mds1), .MD_BUSY(mdb1)
`ifdef PIPE_PERF_CNT_EN
        , .STALL_CYCLES(stall1), .FLUSH_EVENTS(flush1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already applied; check the combinational response, update the
    // counter model from the expected vector, then advance one cycle.
    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {24'd0, out0}, {24'd0, exp});
        if (RESET) begin
            if (!exp[7])      exp_stall++;
            if (exp == REDIR) exp_flush++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "_stall"}, stall0, exp_stall);
        chk({tag, "_flush"}, flush0, exp_flush);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    initial begin
        RESET = 1'b0; BUSYWAIT = 1'b0;
        ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0;
        ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
        EX_MEMREAD = 1'b0; EX_MULDIV = 1'b0; EX_REDIRECT = 1'b0;
        @(posedge CLK); #1;

        // Reset with hostile inputs: everything frozen
        BUSYWAIT = 1'b1; EX_MULDIV = 1'b1;
        #1 chk("rst_l1", {24'd0, out1}, 32'd0);
        for (int i = 0; i < 3; i++) step("rst", OFF);
        chk_cnt("rst");
        RESET = 1'b1; BUSYWAIT = 1'b0; EX_MULDIV = 1'b0;
        step("rst_release", RUNW);

        // BUSYWAIT in RUN freezes everything
        BUSYWAIT = 1'b1;
        step("bw_run", OFF);
        BUSYWAIT = 1'b0;

        // Load-use on RS2, one bubble then the load leaves EX
        EX_MEMREAD = 1'b1; EX_RD = 5'd5; ID_USES_RS2 = 1'b1; ID_RS2 = 5'd5;
        step("lu_rs2", LU);
        EX_MEMREAD = 1'b0;
        step("lu_done", RUNW);
        // Same pattern with x0 as destination: no stall
        EX_MEMREAD = 1'b1; EX_RD = 5'd0; ID_RS2 = 5'd0;
        step("lu_x0", RUNW);
        // RS1 match, then the same register but RS1 not used
        EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b1; ID_USES_RS2 = 1'b0;
        step("lu_rs1", LU);
        ID_USES_RS1 = 1'b0;
        step("lu_rs1_unused", RUNW);
        chk_cnt("lu");

        // Redirect together with load-use: redirect wins, no stall
        ID_USES_RS1 = 1'b1;
        EX_REDIRECT = 1'b1;
        step("redir_lu", REDIR);
        chk_cnt("redir");
        EX_REDIRECT = 1'b0; EX_MEMREAD = 1'b0; ID_USES_RS1 = 1'b0;
        step("idle", RUNW);

        // MUL/DIV, latency 4: start, two waits, release
        EX_MULDIV = 1'b1;
        #1 chk("md_l1_ignored", {24'd0, out1}, {24'd0, RUNW});
        step("md_start", START);
        step("md_wait1", WAIT);
        step("md_wait2", WAIT);
        step("md_release", REL);
        EX_MULDIV = 1'b0;
        step("md_after", RUNW);
        chk_cnt("md");

        // BUSYWAIT overlapping the wait, cycles 2..5 of the op
        EX_MULDIV = 1'b1;
        step("bw_md_start", START);
        step("bw_md_wait1", WAIT);
        BUSYWAIT = 1'b1;
        for (int c = 2; c <= 5; c++) step("bw_md_busy", WAIT);
        BUSYWAIT = 1'b0;
        step("bw_md_release", REL);
        EX_MULDIV = 1'b0;
        step("bw_md_after", RUNW);
        chk_cnt("bw_md");

        // Reset asserted in the first wait cycle aborts the op
        EX_MULDIV = 1'b1;
        step("rm_start", START);
        #2 RESET = 1'b0;
        #1 chk("rm_async", {24'd0, out0}, {24'd0, OFF});
        exp_stall = 0; exp_flush = 0;
        chk_cnt("rm_async");
        @(posedge CLK); #1;
        RESET = 1'b1; EX_MULDIV = 1'b0;
        step("rm_run", RUNW);
        step("rm_run2", RUNW);
        chk_cnt("rm_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RV32IM pipeline. Each cycle it decides whether the PC, IF_ID, ID_EX and EX_MEM registers load, hold or bubble. It resolves four conditions: memory busy-wait, multi-cycle M-extension operations in EX, control redirects resolved in EX, and load-use hazards between ID and EX. It sits beside the pipeline registers and drives their write-enable and flush inputs.

## Interface
Parameters:
- MD_LATENCY, 32, EX occupancy in cycles of a MUL/DIV instruction (≥1)

Ports:
- CLK  in  1  pipeline clock
- RESET  in  1  asynchronous, active-low reset
- BUSYWAIT  in  1  instruction or data memory not ready
- ID_RS1, ID_RS2  in  5 each  source registers of instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1 each  instruction in ID reads that source
- EX_RD  in  5  destination of instruction in EX (ID_EX output)
- EX_MEMREAD  in  1  instruction in EX is a load
- EX_MULDIV  in  1  instruction in EX is an M-extension op
- EX_REDIRECT  in  1  branch taken or jump resolved in EX
- PC_WRITE  out  1  PC loads next value
- IF_ID_WRITE  out  1  IF_ID loads
- IF_ID_FLUSH  out  1  IF_ID loads a NOP
- ID_EX_WRITE  out  1  ID_EX loads
- ID_EX_FLUSH  out  1  ID_EX loads a bubble (all control bits 0)
- EX_MEM_WRITE  out  1  EX_MEM loads
- MD_START  out  1  one-cycle start pulse to MUL/DIV unit
- MD_BUSY  out  1  FSM in MD_WAIT

## Operation
- State is RUN or MD_WAIT, plus the down-counter MD_CNT of width $clog2(MD_LATENCY), minimum 1.
- Load-use hazard (LU): EX_MEMREAD & EX_RD≠0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- Rules are applied in priority order; the first match wins:
  1. BUSYWAIT=1, in any state: all write enables 0, flushes 0, MD_START 0. State holds. MD_CNT still decrements in MD_WAIT until it reaches 0.
  2. RUN & EX_MULDIV & MD_LATENCY≥2: MD_START=1 and all write enables 0. Load MD_CNT=MD_LATENCY-2 and go to MD_WAIT.
  3. MD_WAIT & MD_CNT≠0: all write enables 0 and MD_CNT decrements.
  4. MD_WAIT & MD_CNT==0 (release): all write enables 1 and go to RUN. LU and redirect are not evaluated in this cycle.
  5. EX_REDIRECT: all write enables 1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
  6. LU: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_WRITE=1, ID_EX_FLUSH=1, EX_MEM_WRITE=1. This inserts exactly one bubble.
  7. Otherwise all write enables 1 and flushes 0.
- With MD_LATENCY=1, EX_MULDIV is ignored and MD_WAIT is never entered.
- Redirect and LU in the same cycle: redirect wins with no stall, because the ID instruction is squashed.
- LU with EX_RD=0 produces no stall.
- A flush is only ever asserted together with the write enable of the same register.

## Timing
- State, MD_CNT and the performance counters update on posedge CLK. All outputs are combinational from the current state and inputs, valid within the same cycle.
- While RESET=0: state=RUN, MD_CNT=0, counters=0, and every output is 0 (pipeline frozen). Reset takes effect asynchronously; deassertion is sampled at the next posedge.
- RESET asserted during MD_WAIT aborts the wait immediately. No MD_START is issued after reset unless a new EX_MULDIV is seen in RUN.
- MUL/DIV occupies EX for exactly MD_LATENCY cycles, i.e. MD_LATENCY-1 stall cycles, plus any BUSYWAIT cycles that overlap the release.
- MD_START is high for exactly one cycle per MUL/DIV instruction.
- LU costs 1 cycle; a redirect costs 2 squashed instructions and 0 frozen cycles.

## Configuration
- PIPE_PERF_CNT_EN defined: adds outputs STALL_CYCLES (out, 32) and FLUSH_EVENTS (out, 32).
  - STALL_CYCLES increments on every cycle with RESET=1 and PC_WRITE=0.
  - FLUSH_EVENTS increments on every cycle in which rule 5 fires.
  - Both wrap modulo 2^32 and are reset to 0.
- Not defined: neither the ports nor the counter logic exist.

## Test plan
- Reset: hold RESET=0 for 3 cycles with BUSYWAIT=1 and EX_MULDIV=1 → all outputs 0. Release → PC_WRITE=1 and MD_START behaves per rule 2 on the first active edge.
- Load-use: EX_MEMREAD=1, EX_RD=5, ID_USES_RS2=1, ID_RS2=5 → one cycle of PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1. Repeat with EX_RD=0 → no stall.
- Redirect+LU: EX_REDIRECT=1 with the LU condition true → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WRITE=1. FLUSH_EVENTS goes 0→1.
- MUL/DIV: MD_LATENCY=4, EX_MULDIV=1 → MD_START pulse in cycle 0, writes 0 in cycles 0–2, release in cycle 3. STALL_CYCLES=3.
- BUSYWAIT overlap: MD_LATENCY=4, BUSYWAIT=1 in cycles 2–5 → MD_CNT reaches 0 by cycle 2, release delayed to cycle 6, still a single MD_START.
- Reset mid-op: RESET=0 in cycle 1 of MD_WAIT → MD_BUSY drops immediately, state=RUN after deassertion, no spurious release.
